// File: rtl/dds_phase_accum_if.sv
// Control-word handshake bus for the DDS phase accumulator.
// The master presents PhaseInc/FreqMod/PhaseMod with cfg_valid; the slave answers with cfg_ready.
interface dds_phase_accum_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] PhaseInc;
    logic [ACC_W-1:0] FreqMod;
    logic [OUT_W-1:0] PhaseMod;

    modport master (
        output cfg_valid,
        output PhaseInc,
        output FreqMod,
        output PhaseMod,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  PhaseInc,
        input  FreqMod,
        input  PhaseMod,
        output cfg_ready
    );
endinterface

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator with shadowed frequency/phase control words.
// New words are applied on the first enabled sample or at accumulator wrap.
module dds_phase_accum #(
    parameter int ACC_W       = 32,
    parameter int OUT_W       = 16,
    parameter int WRAP_UPDATE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clken,
    input  logic             sync_clr,
    dds_phase_accum_if.slave cfg,
    output logic [OUT_W-1:0] phase_out,
    output logic             phase_valid,
    output logic             wrap_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_from_idle;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sh_inc;
    logic [ACC_W-1:0] r_inc;
    logic [OUT_W-1:0] r_sh_pm;
    logic [OUT_W-1:0] r_pm;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_capture;
    logic             w_advance;
    logic             w_apply;

    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry   = w_sum[ACC_W];
    assign w_capture = cfg.cfg_valid && cfg.cfg_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_from_idle <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_from_idle <= (r_state == IDLE);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE,
            RUN:     if (w_capture) w_state_nxt = PEND;
            PEND:    if (w_apply)   w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A set pending from IDLE has no running accumulator to wait on, so it
    // applies on the first enabled edge without advancing the phase.
    always_comb begin
        cfg.cfg_ready = 1'b0;
        w_advance     = 1'b0;
        w_apply       = 1'b0;
        case (r_state)
            IDLE: cfg.cfg_ready = 1'b1;
            RUN: begin
                cfg.cfg_ready = 1'b1;
                w_advance     = clken;
            end
            PEND: begin
                if (r_from_idle) begin
                    w_apply = clken;
                end else begin
                    w_advance = clken;
                    w_apply   = clken && ((WRAP_UPDATE != 0) ? w_carry : 1'b1);
                end
            end
            default: cfg.cfg_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_sh_inc    <= '0;
            r_inc       <= '0;
            r_sh_pm     <= '0;
            r_pm        <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sh_inc <= cfg.PhaseInc + cfg.FreqMod;
                r_sh_pm  <= cfg.PhaseMod;
            end
            if (w_apply) begin
                r_inc <= r_sh_inc;
                r_pm  <= r_sh_pm;
            end
            if (sync_clr) begin
                r_acc <= '0;
            end else if (w_advance) begin
                r_acc <= w_sum[ACC_W-1:0];
            end
            if (w_advance) begin
                phase_out <= r_acc[ACC_W-1 -: OUT_W] + r_pm;
            end
            phase_valid <= w_advance;
            wrap_pulse  <= w_advance && w_carry && !sync_clr;
        end
    end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Directed self-checking bench for dds_phase_accum (default parameters, wrap-aligned update).
module tb_dds_phase_accum;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic        sync_clr;
    logic [15:0] phase_out;
    logic        phase_valid;
    logic        wrap_pulse;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    dds_phase_accum_if #(.ACC_W(32), .OUT_W(16)) u_if ();

    dds_phase_accum #(
        .ACC_W       (32),
        .OUT_W       (16),
        .WRAP_UPDATE (1)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clken       (clken),
        .sync_clr    (sync_clr),
        .cfg         (u_if),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .wrap_pulse  (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] inc, input logic [31:0] fm, input logic [15:0] pm);
        u_if.cfg_valid = 1'b1;
        u_if.PhaseInc  = inc;
        u_if.FreqMod   = fm;
        u_if.PhaseMod  = pm;
        step();
        u_if.cfg_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        clken   = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    logic [15:0] t1_po [8]  = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                                16'h0000, 16'h4000, 16'h8000, 16'hC000};
    logic [15:0] t2_po [6]  = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h2000, 16'h4000};
    logic        t2_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        t2_wr  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        t4_en  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] t4_po  [5] = '{16'h0100, 16'h0100, 16'h1100, 16'h1100, 16'h2100};

    initial begin
        reset_n        = 1'b0;
        clken          = 1'b0;
        sync_clr       = 1'b0;
        u_if.cfg_valid = 1'b0;
        u_if.PhaseInc  = '0;
        u_if.FreqMod   = '0;
        u_if.PhaseMod  = '0;
        #1;
        check("rst_phase_out",   32'(phase_out),   32'h0);
        check("rst_phase_valid", 32'(phase_valid), 32'h0);
        check("rst_wrap",        32'(wrap_pulse),  32'h0);
        check("rst_cfg_ready",   32'(u_if.cfg_ready), 32'h1);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("idle_phase_valid", 32'(phase_valid), 32'h0);

        // quarter-turn increment from IDLE
        load(32'h4000_0000, 32'h0, 16'h0);
        check("t1_ready_pend", 32'(u_if.cfg_ready), 32'h0);
        clken = 1'b1;
        step();
        check("t1_apply_valid", 32'(phase_valid), 32'h0);
        check("t1_apply_ready", 32'(u_if.cfg_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("t1_po%0d", i),    32'(phase_out),   32'(t1_po[i]));
            check($sformatf("t1_valid%0d", i), 32'(phase_valid), 32'h1);
            check($sformatf("t1_wrap%0d", i),  32'(wrap_pulse),  32'((i % 4) == 3));
        end

        // reload while running: new step only after the wrap
        step();
        check("t2_po_pre", 32'(phase_out), 32'h0000);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                u_if.cfg_valid = 1'b1;
                u_if.PhaseInc  = 32'h2000_0000;
                u_if.FreqMod   = 32'h0;
                u_if.PhaseMod  = 16'h0;
            end
            step();
            u_if.cfg_valid = 1'b0;
            check($sformatf("t2_po%0d", i),  32'(phase_out),      32'(t2_po[i]));
            check($sformatf("t2_rdy%0d", i), 32'(u_if.cfg_ready), 32'(t2_rdy[i]));
            check($sformatf("t2_wrap%0d", i), 32'(wrap_pulse),    32'(t2_wr[i]));
        end

        // increment overflow and phase offset
        pulse_reset();
        load(32'hFFFF_FFFF, 32'h0000_0002, 16'hFFFF);
        clken = 1'b1;
        step();
        step();
        check("t3_po0",    32'(phase_out),   32'hFFFF);
        check("t3_valid0", 32'(phase_valid), 32'h1);
        check("t3_wrap0",  32'(wrap_pulse),  32'h0);
        step();
        check("t3_po1",    32'(phase_out),   32'hFFFF);
        check("t3_wrap1",  32'(wrap_pulse),  32'h0);

        // clken gating and sync_clr
        pulse_reset();
        load(32'h1000_0000, 32'h0, 16'h0100);
        clken = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            clken = t4_en[i];
            step();
            check($sformatf("t4_po%0d", i),    32'(phase_out),   32'(t4_po[i]));
            check($sformatf("t4_valid%0d", i), 32'(phase_valid), 32'(t4_en[i]));
        end
        clken    = 1'b1;
        sync_clr = 1'b1;
        step();
        check("t4_clr_wrap", 32'(wrap_pulse), 32'h0);
        sync_clr = 1'b0;
        step();
        check("t4_clr_po",  32'(phase_out), 32'h0100);
        step();
        check("t4_clr_po2", 32'(phase_out), 32'h1100);

        // reset while a set is pending
        load(32'h3000_0000, 32'h0, 16'h0005);
        check("t5_ready_pend", 32'(u_if.cfg_ready), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_po",    32'(phase_out),      32'h0);
        check("t5_rst_valid", 32'(phase_valid),    32'h0);
        check("t5_rst_wrap",  32'(wrap_pulse),     32'h0);
        check("t5_rst_ready", 32'(u_if.cfg_ready), 32'h1);
        step();
        reset_n = 1'b1;
        clken   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_idle_po%0d", i),    32'(phase_out),      32'h0);
            check($sformatf("t5_idle_valid%0d", i), 32'(phase_valid),    32'h0);
            check($sformatf("t5_idle_ready%0d", i), 32'(u_if.cfg_ready), 32'h1);
        end
        load(32'h4000_0000, 32'h0, 16'h0);
        step();
        step();
        check("t5_fresh_po0", 32'(phase_out), 32'h0000);
        step();
        check("t5_fresh_po1", 32'(phase_out), 32'h4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
